preif_stage: RTL and testbench
==============================

Name: preif_stage

Overview:
- Pre-fetch stage (PreIF) directly upstream of the IF stage.
- Owns the fetch PC and issues instruction requests on the inst-SRAM/icache address channel (req / addr_ok).
- Hands {pc, req-issued flag, adef flag} to IF with a valid/allowin handshake.
- Applies exception and branch redirects, and drops stale data_ok responses that belong to cancelled fetches, so IF only ever sees data_ok for its current instruction.

Parameters:
- RESET_PC, 32'h1c000000, fetch PC loaded on reset.
- MAX_OUTSTANDING, 2, maximum accepted-but-unreturned requests (range 1..3); the counters are 2 bits wide.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_allowin_i  in  1  IF can accept a new PC this cycle
- to_if_valid_o  out  1  PC bundle valid towards IF
- pc_o  out  32  fetch PC handed to IF
- req_issued_o  out  1  a SRAM request was issued for pc_o (0 when adef)
- adef_o  out  1  pc_o[1:0]!=0; no request is issued
- excep_flush_i  in  1  exception/ertn redirect (highest priority)
- excep_pc_i  in  32  exception redirect target
- br_flush_i  in  1  branch-mispredict redirect
- br_pc_i  in  32  branch redirect target
- inst_sram_req_o  out  1  request valid
- inst_sram_addr_o  out  32  request address (always equals the PC register)
- inst_sram_addr_ok_i  in  1  request accepted this cycle
- inst_sram_data_ok_i  in  1  raw read data return
- inst_data_ok_o  out  1  filtered data_ok towards IF

Behaviour:
- State machine: REQ (issuing for the current PC) and READY (PC accepted or adef; waiting for IF).
- Reset: pc = RESET_PC, state = REQ, outstanding = 0, cancel_cnt = 0. At reset all outputs are 0 except pc_o and inst_sram_addr_o, which show RESET_PC.
- inst_sram_req_o = (state==REQ) && !adef && outstanding<MAX_OUTSTANDING && !excep_flush_i && !br_flush_i.
- A request is "accepted" when inst_sram_req_o && inst_sram_addr_ok_i. On acceptance: state goes to READY and req_issued is registered as 1.
- adef in REQ: no request; next cycle state = READY with req_issued = 0 and adef_o = 1.
- to_if_valid_o = (state==READY) && !excep_flush_i && !br_flush_i.
- Handoff: to_if_valid_o && if_allowin_i. Next cycle: pc += 4 (32-bit wrap), state = REQ, req_issued = 0.
- Handoff latency: an SRAM that grants addr_ok in the request cycle gives one PC per 2 cycles. Back-to-back REQ->READY->REQ is required; no bubble is inserted beyond that.
- outstanding counter:
  - +1 on acceptance, -1 on raw data_ok; both in the same cycle means no change.
  - Never exceeds MAX_OUTSTANDING.
  - A data_ok with outstanding==0 is a protocol error; the counter saturates at 0.
- Flush: excep_flush_i has priority over br_flush_i. Next cycle:
  - pc = target;
  - state = REQ;
  - cancel_cnt = outstanding + accepted_this_cycle - data_ok_this_cycle.
  - Accepted_this_cycle is always 0 during flush, because req is masked.
  - All in-flight requests are stale, including the one whose PC was already handed to IF; IF is flushed by the same signal.
- inst_data_ok_o = inst_sram_data_ok_i && cancel_cnt==0.
- While cancel_cnt>0, each raw data_ok decrements cancel_cnt (and outstanding) and is swallowed.
- New requests may issue while cancel_cnt>0, because returns are in order and the counter sorts them.
- Flush coinciding with a handoff: the flush wins. There is no handoff and pc does not increment.
- Flush asserted for several consecutive cycles: the last target wins, and cancel_cnt is recomputed each cycle by the same formula.
- Reset mid-operation clears every counter. The memory side is reset concurrently, so no stale returns are expected.
- inst_sram_addr_o changes only when the PC register changes. It is stable while req is held and addr_ok is low.

Test Plan:
- Reset release, addr_ok in the same cycle as req, if_allowin_i=1: addr = 1c000000 then 1c000004, 1c000008, one handoff every 2 cycles; to_if_valid_o high in the READY cycles.
- addr_ok delayed 3 cycles: req held with addr = 1c000000 stable; to_if_valid_o stays 0 until the cycle after addr_ok.
- if_allowin_i=0 for 4 cycles while READY: pc_o held, no new req, to_if_valid_o stays 1; handoff on release.
- 2 requests outstanding, then excep_flush_i with excep_pc_i=1c008000: the next 2 raw data_ok produce inst_data_ok_o=0; the new request is to 1c008000; its data_ok passes through.
- br_flush_i=1 and excep_flush_i=1 in the same cycle (br_pc=1c000100, excep_pc=1c008000): next pc = 1c008000.
- br_flush_i to 1c000102: no req, adef_o=1, req_issued_o=0, to_if_valid_o=1 on the next cycle; handoff moves to 1c000106 (still adef).

Source files
------------

// File: rtl/preif_stage.sv
// Pre-fetch stage: owns the fetch PC, issues inst-SRAM requests, hands the PC to IF
// and swallows data_ok returns that belong to fetches cancelled by a redirect.
module preif_stage #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_allowin_i,
  output logic        to_if_valid_o,
  output logic [31:0] pc_o,
  output logic        req_issued_o,
  output logic        adef_o,
  input  logic        excep_flush_i,
  input  logic [31:0] excep_pc_i,
  input  logic        br_flush_i,
  input  logic [31:0] br_pc_i,
  output logic        inst_sram_req_o,
  output logic [31:0] inst_sram_addr_o,
  input  logic        inst_sram_addr_ok_i,
  input  logic        inst_sram_data_ok_i,
  output logic        inst_data_ok_o
);

  localparam logic [1:0] LP_MAX = 2'(MAX_OUTSTANDING);

  typedef enum logic {
    S_REQ,
    S_READY
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_req_issued, w_req_issued_nxt;
  logic [1:0]  r_outstanding, w_outstanding_nxt;
  logic [1:0]  r_cancel_cnt, w_cancel_nxt;

  logic        w_adef, w_flush, w_req, w_accept, w_valid, w_handoff, w_dok_eff;
  logic [31:0] w_flush_pc;

  always_comb begin
    w_adef     = (r_pc[1:0] != 2'b00);
    w_flush    = excep_flush_i | br_flush_i;
    w_flush_pc = excep_flush_i ? excep_pc_i : br_pc_i;
    w_req      = !rst && (r_state == S_REQ) && !w_adef &&
                 (r_outstanding < LP_MAX) && !w_flush;
    w_accept   = w_req && inst_sram_addr_ok_i;
    w_valid    = !rst && (r_state == S_READY) && !w_flush;
    w_handoff  = w_valid && if_allowin_i;
    // A data_ok with nothing outstanding is a protocol error; ignore it so the count saturates at 0
    w_dok_eff  = inst_sram_data_ok_i && (r_outstanding != 2'd0);

    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_req_issued_nxt  = r_req_issued;
    w_outstanding_nxt = r_outstanding + {1'b0, w_accept} - {1'b0, w_dok_eff};
    w_cancel_nxt      = r_cancel_cnt;

    if (w_flush) begin
      // Every in-flight request is stale, including the one already handed to IF
      w_pc_nxt         = w_flush_pc;
      w_state_nxt      = S_REQ;
      w_req_issued_nxt = 1'b0;
      w_cancel_nxt     = w_outstanding_nxt;
    end else begin
      if (inst_sram_data_ok_i && (r_cancel_cnt != 2'd0))
        w_cancel_nxt = r_cancel_cnt - 2'd1;
      unique case (r_state)
        S_REQ: begin
          if (w_adef) begin
            w_state_nxt      = S_READY;
            w_req_issued_nxt = 1'b0;
          end else if (w_accept) begin
            w_state_nxt      = S_READY;
            w_req_issued_nxt = 1'b1;
          end
        end
        S_READY: begin
          if (w_handoff) begin
            w_pc_nxt         = r_pc + 32'd4;
            w_state_nxt      = S_REQ;
            w_req_issued_nxt = 1'b0;
          end
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_req_issued  <= 1'b0;
      r_outstanding <= '0;
      r_cancel_cnt  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_req_issued  <= w_req_issued_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_cancel_cnt  <= w_cancel_nxt;
    end
  end

  assign to_if_valid_o    = w_valid;
  assign pc_o             = r_pc;
  assign req_issued_o     = r_req_issued;
  assign adef_o           = w_adef;
  assign inst_sram_req_o  = w_req;
  assign inst_sram_addr_o = r_pc;
  assign inst_data_ok_o   = !rst && inst_sram_data_ok_i && (r_cancel_cnt == 2'd0);

endmodule

// File: tb/tb_preif_stage.sv
// Cycle-by-cycle directed vectors for preif_stage, followed by a hand-written
// mid-operation reset sequence.
module tb_preif_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_allowin_i;
  logic        to_if_valid_o;
  logic [31:0] pc_o;
  logic        req_issued_o;
  logic        adef_o;
  logic        excep_flush_i;
  logic [31:0] excep_pc_i;
  logic        br_flush_i;
  logic [31:0] br_pc_i;
  logic        inst_sram_req_o;
  logic [31:0] inst_sram_addr_o;
  logic        inst_sram_addr_ok_i;
  logic        inst_sram_data_ok_i;
  logic        inst_data_ok_o;

  preif_stage #(.RESET_PC(32'h1c000000), .MAX_OUTSTANDING(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .if_allowin_i        (if_allowin_i),
    .to_if_valid_o       (to_if_valid_o),
    .pc_o                (pc_o),
    .req_issued_o        (req_issued_o),
    .adef_o              (adef_o),
    .excep_flush_i       (excep_flush_i),
    .excep_pc_i          (excep_pc_i),
    .br_flush_i          (br_flush_i),
    .br_pc_i             (br_pc_i),
    .inst_sram_req_o     (inst_sram_req_o),
    .inst_sram_addr_o    (inst_sram_addr_o),
    .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
    .inst_sram_data_ok_i (inst_sram_data_ok_i),
    .inst_data_ok_o      (inst_data_ok_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, alw, ef;
    logic [31:0] epc;
    logic        bf;
    logic [31:0] bpc;
    logic        aok, dok;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_ri, e_adef, e_req, e_dok;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic a, input logic ef, input logic [31:0] epc,
                     input logic bf, input logic [31:0] bpc, input logic aok, input logic dok,
                     input logic ev, input logic [31:0] epc_o, input logic eri,
                     input logic ead, input logic erq, input logic edk);
    vec_t v;
    v = '{rst:r, alw:a, ef:ef, epc:epc, bf:bf, bpc:bpc, aok:aok, dok:dok,
          e_valid:ev, e_pc:epc_o, e_ri:eri, e_adef:ead, e_req:erq, e_dok:edk};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic ef, input logic [31:0] epc,
                       input logic bf, input logic [31:0] bpc, input logic aok, input logic dok);
    @(posedge clk);
    #2;
    rst = r; if_allowin_i = a; excep_flush_i = ef; excep_pc_i = epc;
    br_flush_i = bf; br_pc_i = bpc; inst_sram_addr_ok_i = aok; inst_sram_data_ok_i = dok;
    #3;
  endtask

  localparam logic [31:0] PB = 32'h1c000000;
  localparam logic [31:0] PX = 32'h1c008000;
  localparam logic [31:0] Z  = 32'h0;

  initial begin
    rst = 1'b1; if_allowin_i = 1'b0; excep_flush_i = 1'b0; excep_pc_i = Z;
    br_flush_i = 1'b0; br_pc_i = Z; inst_sram_addr_ok_i = 1'b0; inst_sram_data_ok_i = 1'b0;

    //   rst alw ef epc  bf bpc  aok dok | valid pc  ri adef req dok_o
    add(1, 0, 0, Z,  0, Z, 0, 0,   0, PB,        0, 0, 0, 0);  // reset state
    // addr_ok in request cycle: one handoff every 2 cycles
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB,        0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 1, 1,   1, PB,        1, 0, 0, 1);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+4,      0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 1, 1,   1, PB+4,      1, 0, 0, 1);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+8,      0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 1, 1,   1, PB+8,      1, 0, 0, 1);
    // addr_ok delayed 3 cycles
    add(0, 1, 0, Z,  0, Z, 0, 0,   0, PB+12,     0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 0, 0,   0, PB+12,     0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 0, 0,   0, PB+12,     0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+12,     0, 0, 1, 0);
    // IF stalls 4 cycles in READY
    add(0, 0, 0, Z,  0, Z, 1, 0,   1, PB+12,     1, 0, 0, 0);
    add(0, 0, 0, Z,  0, Z, 1, 1,   1, PB+12,     1, 0, 0, 1);
    add(0, 0, 0, Z,  0, Z, 1, 0,   1, PB+12,     1, 0, 0, 0);
    add(0, 0, 0, Z,  0, Z, 1, 0,   1, PB+12,     1, 0, 0, 0);
    add(0, 1, 0, Z,  0, Z, 0, 0,   1, PB+12,     1, 0, 0, 0);
    // two outstanding, limit reached, then exception flush
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+16,     0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 0, 0,   1, PB+16,     1, 0, 0, 0);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+20,     0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 0, 0,   1, PB+20,     1, 0, 0, 0);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+24,     0, 0, 0, 0);
    add(0, 1, 1, PX, 0, Z, 1, 0,   0, PB+24,     0, 0, 0, 0);
    add(0, 1, 0, Z,  0, Z, 1, 1,   0, PX,        0, 0, 0, 0);
    add(0, 1, 0, Z,  0, Z, 1, 1,   0, PX,        0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 0, 1,   1, PX,        1, 0, 0, 1);
    // exception and branch flush together: exception target wins
    add(0, 1, 1, PX, 1, PB+32'h100, 1, 0,   0, PX+4, 0, 0, 0, 0);
    add(0, 1, 0, Z,  0, Z, 0, 0,   0, PX,        0, 0, 1, 0);
    // branch to a misaligned target
    add(0, 1, 0, Z,  1, PB+32'h102, 0, 0,   0, PX, 0, 0, 1'b0, 0);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+32'h102, 0, 1, 0, 0);
    add(0, 0, 0, Z,  0, Z, 1, 0,   1, PB+32'h102, 0, 1, 0, 0);
    add(0, 1, 0, Z,  0, Z, 1, 0,   1, PB+32'h102, 0, 1, 0, 0);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+32'h106, 0, 1, 0, 0);
    add(0, 0, 0, Z,  0, Z, 1, 0,   1, PB+32'h106, 0, 1, 0, 0);
    // flush coinciding with a would-be handoff
    add(0, 1, 0, Z,  1, PB+32'h200, 1, 0,   0, PB+32'h106, 0, 1, 0, 0);
    add(0, 1, 0, Z,  0, Z, 0, 0,   0, PB+32'h200, 0, 0, 1, 0);
    // stray data_ok with nothing outstanding must not underflow the counter
    add(0, 1, 0, Z,  0, Z, 0, 1,   0, PB+32'h200, 0, 0, 1, 1);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+32'h200, 0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 0, 0,   1, PB+32'h200, 1, 0, 0, 0);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+32'h204, 0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 0, 0,   1, PB+32'h204, 1, 0, 0, 0);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+32'h208, 0, 0, 0, 0);
    // two-cycle flush: last target wins, cancel count recomputed each cycle
    add(0, 1, 1, PB+32'h300, 0, Z, 1, 1,   0, PB+32'h208, 0, 0, 0, 1);
    add(0, 1, 0, Z,  1, PB+32'h400, 1, 0,   0, PB+32'h300, 0, 0, 0, 0);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+32'h400, 0, 0, 1, 0);
    add(0, 1, 0, Z,  0, Z, 0, 1,   1, PB+32'h400, 1, 0, 0, 0);
    add(0, 1, 0, Z,  0, Z, 0, 1,   0, PB+32'h404, 0, 0, 1, 1);
    add(0, 1, 0, Z,  0, Z, 1, 0,   0, PB+32'h404, 0, 0, 1, 0);

    repeat (2) @(posedge clk);
    for (int unsigned i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].alw, vq[i].ef, vq[i].epc, vq[i].bf, vq[i].bpc, vq[i].aok, vq[i].dok);
      chk($sformatf("v%0d.valid", i),   {31'd0, to_if_valid_o},   {31'd0, vq[i].e_valid});
      chk($sformatf("v%0d.pc", i),      pc_o,                     vq[i].e_pc);
      chk($sformatf("v%0d.addr", i),    inst_sram_addr_o,         vq[i].e_pc);
      chk($sformatf("v%0d.req_iss", i), {31'd0, req_issued_o},    {31'd0, vq[i].e_ri});
      chk($sformatf("v%0d.adef", i),    {31'd0, adef_o},          {31'd0, vq[i].e_adef});
      chk($sformatf("v%0d.req", i),     {31'd0, inst_sram_req_o}, {31'd0, vq[i].e_req});
      chk($sformatf("v%0d.data_ok", i), {31'd0, inst_data_ok_o},  {31'd0, vq[i].e_dok});
    end

    // Reset mid-operation (one request outstanding): counters must clear
    drive(1, 1, 0, Z, 0, Z, 1, 0);
    chk("rst.req",   {31'd0, inst_sram_req_o}, 32'd0);
    chk("rst.valid", {31'd0, to_if_valid_o},   32'd0);
    drive(0, 0, 0, Z, 0, Z, 1, 0);
    chk("post_rst.pc",  pc_o,                      PB);
    chk("post_rst.req", {31'd0, inst_sram_req_o},  32'd1);
    drive(0, 1, 0, Z, 0, Z, 0, 0);
    chk("post_rst.valid", {31'd0, to_if_valid_o},  32'd1);
    drive(0, 1, 0, Z, 0, Z, 1, 0);
    chk("post_rst.req2", {31'd0, inst_sram_req_o}, 32'd1);
    chk("post_rst.pc2",  pc_o,                     PB + 4);
    drive(0, 1, 0, Z, 0, Z, 0, 0);
    chk("post_rst.valid2", {31'd0, to_if_valid_o}, 32'd1);
    drive(0, 1, 0, Z, 0, Z, 1, 0);
    chk("post_rst.limit", {31'd0, inst_sram_req_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
